// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus for one side of pipe_stage_reg: payload, control bundle and handshake.
// The producer drives valid/data/ctrl (master), the consumer drives ready (slave).
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional 2-entry skid buffer (SKID=1) and flush.
// Optional statistics counters are compiled in with macro PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_stage_reg_if.slave       up_if,
  pipe_stage_reg_if.master      dn_if,
  input  logic                  flush,
  output logic [1:0]            occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  localparam bit USE_SKID = (SKID != 0);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire, main_free;

  // Handshake: a beat transfers on a rising edge where valid && ready on that side;
  // the producer holds valid/data/ctrl until the beat transfers; ready never depends on in valid.
  // With the skid buffer, ready comes straight from a flop (skid empty).
  assign up_if.ready = USE_SKID ? (~reset & ~skid_valid_q)
                                : (~reset & (dn_if.ready | ~main_valid_q));

  assign in_fire   = up_if.valid & up_if.ready;
  assign out_fire  = main_valid_q & dn_if.ready;
  assign main_free = ~main_valid_q | out_fire;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) main_valid_d = 1'b0;
      if (skid_valid_q && out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (in_fire && main_free) begin
        main_valid_d = 1'b1;
        main_data_d  = up_if.data;
        main_ctrl_d  = up_if.ctrl;
      end else if (USE_SKID && in_fire) begin
        skid_valid_d = 1'b1;
        skid_data_d  = up_if.data;
        skid_ctrl_d  = up_if.ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  // A bubble must never present MemWr/RegWr downstream.
  assign dn_if.valid = main_valid_q;
  assign dn_if.data  = main_data_q;
  assign dn_if.ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !dn_if.ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && occupancy != 2'd0 && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share one stimulus stream and are
// each checked against a queue-based reference; table vectors pin down the directed scenarios.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_ready;
  logic        flush;
  logic [1:0]  occ0, occ1;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) up0 ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) dn0 ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) up1 ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) dn1 ();

  assign up0.valid = in_valid;
  assign up0.data  = in_data;
  assign up0.ctrl  = in_ctrl;
  assign dn0.ready = out_ready;
  assign up1.valid = in_valid;
  assign up1.data  = in_data;
  assign up1.ctrl  = in_ctrl;
  assign dn1.ready = out_ready;

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall0, fcnt0, stall1, fcnt1;
`endif

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .up_if(up0), .dn_if(dn0), .flush(flush), .occupancy(occ0)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall0), .flush_cnt(fcnt0)
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .up_if(up1), .dn_if(dn1), .flush(flush), .occupancy(occ1)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall1), .flush_cnt(fcnt1)
`endif
  );

  logic [1:0]  ov_s, ir_s;
  logic [31:0] od_s [2];
  logic [7:0]  oc_s [2];
  logic [1:0]  occ_s [2];
  assign ov_s     = {dn1.valid, dn0.valid};
  assign ir_s     = {up1.ready, up0.ready};
  assign od_s[0]  = dn0.data;
  assign od_s[1]  = dn1.data;
  assign oc_s[0]  = dn0.ctrl;
  assign oc_s[1]  = dn1.ctrl;
  assign occ_s[0] = occ0;
  assign occ_s[1] = occ1;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected queue of {ctrl, data} per instance
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int exp_size(input int k);
    return (k == 1) ? exp_q1.size() : exp_q0.size();
  endfunction

  // Capacity 2 with ready = "not full" for the skid build; capacity 1 with pass-through ready otherwise.
  function automatic logic exp_ready(input int k);
    if (k == 1) return exp_size(1) < 2;
    return out_ready || exp_size(0) == 0;
  endfunction

  task automatic check_model(input int k);
    int          n;
    logic [39:0] head;
    string       tag;
    tag  = (k == 1) ? "skid1" : "skid0";
    n    = exp_size(k);
    head = '0;
    if (n > 0) head = (k == 1) ? exp_q1[0] : exp_q0[0];
    check($sformatf("%s in_ready", tag), 64'(ir_s[k]), 64'(exp_ready(k)));
    check($sformatf("%s out_valid", tag), 64'(ov_s[k]), 64'(n > 0));
    check($sformatf("%s occupancy", tag), 64'(occ_s[k]), 64'(n));
    check($sformatf("%s out_ctrl", tag), 64'(oc_s[k]), (n > 0) ? 64'(head[39:32]) : 64'd0);
    if (n > 0) check($sformatf("%s out_data", tag), 64'(od_s[k]), 64'(head[31:0]));
  endtask

  task automatic model_step();
    logic fi0, fi1, fo0, fo1;
    fi0 = in_valid && exp_ready(0);
    fi1 = in_valid && exp_ready(1);
    fo0 = exp_size(0) > 0 && out_ready;
    fo1 = exp_size(1) > 0 && out_ready;
    if (flush) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (fo0) void'(exp_q0.pop_front());
      if (fo1) void'(exp_q1.pop_front());
      if (fi0) exp_q0.push_back({in_ctrl, in_data});
      if (fi1) exp_q1.push_back({in_ctrl, in_data});
    end
  endtask

  // driver tasks: drive at the falling edge, check 1 ns later, update the model at the rising edge
  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = iv ? d : $urandom;
    in_ctrl   = iv ? c : 8'($urandom);
    out_ready = ordy;
    flush     = fl;
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                              input logic ov, input logic [31:0] od, input logic [1:0] occ,
                              input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  initial begin
    vec_t        v;
    logic [7:0]  exp_c;
    logic [31:0] rd;
    // streaming
    vecs.push_back(mk(1, 32'h11, 1, 0, 0, 32'h0,  0, 1));
    vecs.push_back(mk(1, 32'h22, 1, 0, 1, 32'h11, 1, 1));
    vecs.push_back(mk(1, 32'h33, 1, 0, 1, 32'h22, 1, 1));
    vecs.push_back(mk(1, 32'h44, 1, 0, 1, 32'h33, 1, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'h44, 1, 1));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 32'h0,  0, 1));
    // backpressure
    vecs.push_back(mk(1, 32'hA,  0, 0, 0, 32'h0,  0, 1));
    vecs.push_back(mk(1, 32'hB,  0, 0, 1, 32'hA,  1, 1));
    vecs.push_back(mk(1, 32'hC,  0, 0, 1, 32'hA,  2, 0));
    vecs.push_back(mk(1, 32'hC,  1, 0, 1, 32'hA,  2, 0));
    vecs.push_back(mk(1, 32'hC,  1, 0, 1, 32'hB,  1, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'hC,  1, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0, 0, 32'h0,  0, 1));
    // flush with two held, then flush racing an accepted input
    vecs.push_back(mk(1, 32'h1,  0, 0, 0, 32'h0,  0, 1));
    vecs.push_back(mk(1, 32'h2,  0, 0, 1, 32'h1,  1, 1));
    vecs.push_back(mk(1, 32'h55, 0, 1, 1, 32'h1,  2, 0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 0, 32'h0,  0, 1));
    vecs.push_back(mk(1, 32'h66, 0, 0, 0, 32'h0,  0, 1));
    vecs.push_back(mk(1, 32'h55, 0, 1, 1, 32'h66, 1, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0, 0, 32'h0,  0, 1));
    vecs.push_back(mk(0, 32'h0,  1, 0, 0, 32'h0,  0, 1));

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d out_valid", k), 64'(ov_s[k]), 64'd0);
      check($sformatf("rst%0d out_data", k), 64'(od_s[k]), 64'd0);
      check($sformatf("rst%0d out_ctrl", k), 64'(oc_s[k]), 64'd0);
      check($sformatf("rst%0d occupancy", k), 64'(occ_s[k]), 64'd0);
      check($sformatf("rst%0d in_ready", k), 64'(ir_s[k]), 64'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // table-driven directed vectors (expectations are for the SKID=1 instance)
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.iv, v.d, {v.d[3:0], 4'h9}, v.ordy, v.fl);
      exp_c = v.ov ? {v.od[3:0], 4'h9} : 8'h00;
      check($sformatf("vec%0d in_ready", i), 64'(up1.ready), 64'(v.ir));
      check($sformatf("vec%0d out_valid", i), 64'(dn1.valid), 64'(v.ov));
      check($sformatf("vec%0d occupancy", i), 64'(occ1), 64'(v.occ));
      check($sformatf("vec%0d out_ctrl", i), 64'(dn1.ctrl), 64'(exp_c));
      if (v.ov) check($sformatf("vec%0d out_data", i), 64'(dn1.data), 64'(v.od));
      advance();
    end

    // single-register combinational ready
    drive(1, 32'h77, 8'h71, 0, 0);
    advance();
    drive(0, 32'h0, 8'h00, 0, 0);
    check("single hold ready", 64'(up0.ready), 64'd0);
    advance();
    drive(1, 32'h78, 8'h81, 1, 0);
    check("single comb ready", 64'(up0.ready), 64'd1);
    advance();
    drive(0, 32'h0, 8'h00, 1, 0);
    check("single swap data", 64'(dn0.data), 64'h78);
    advance();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rd = $urandom;
      drive($urandom_range(0, 9) < 7, rd, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 15) == 0);
      advance();
    end

    // asynchronous reset while full
    drive(0, 32'h0, 8'h00, 1, 0);
    advance();
    drive(1, 32'hA1, 8'h1A, 0, 0);
    advance();
    drive(1, 32'hA2, 8'h2A, 0, 0);
    advance();
    drive(0, 32'h0, 8'h00, 0, 0);
    check("pre-reset occupancy", 64'(occ1), 64'd2);
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async%0d out_valid", k), 64'(ov_s[k]), 64'd0);
      check($sformatf("async%0d out_data", k), 64'(od_s[k]), 64'd0);
      check($sformatf("async%0d out_ctrl", k), 64'(oc_s[k]), 64'd0);
      check($sformatf("async%0d occupancy", k), 64'(occ_s[k]), 64'd0);
      check($sformatf("async%0d in_ready", k), 64'(ir_s[k]), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    drive(1, 32'h99, 8'h9C, 1, 0);
    check("post-reset ready1", 64'(up1.ready), 64'd1);
    check("post-reset ready0", 64'(up0.ready), 64'd1);
    advance();
    drive(0, 32'h0, 8'h00, 1, 0);
    check("post-reset data", 64'(dn1.data), 64'h99);
    advance();

`ifdef PIPE_STAGE_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    drive(1, 32'h5A, 8'hA5, 0, 0);
    advance();
    drive(0, 32'h0, 8'h00, 0, 0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stall_cnt saturate", 64'(stall1), 64'hFFFF);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 8'h00, 0, 1);
      advance();
      if (i < 2) begin
        drive(1, 32'h60 + i, 8'h06, 0, 0);
        advance();
      end
    end
    drive(0, 32'h0, 8'h00, 0, 0);
    check("flush_cnt", 64'(fcnt1), 64'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- DATA_W, 32, width of the data payload (ALU result, addresses).
- CTRL_W, 8, width of the control bundle (MemWr, Branch, MemtoReg, RegWr, PCSrc, ...).
- SKID, 1. 0 gives a single register with combinational ready. 1 adds a 2-entry skid buffer with registered ready.

REQ-002 Ports SHALL be as follows, one per line.
- clk, in, 1, clock; rising edge active.
- reset, in, 1, asynchronous, active-high reset.
- in_valid, in, 1, upstream entry valid.
- in_ready, out, 1, stage accepts an entry this cycle.
- in_data, in, DATA_W, upstream payload.
- in_ctrl, in, CTRL_W, upstream control bundle.
- flush, in, 1, synchronous kill of all held entries (branch or exception squash).
- out_valid, out, 1, head entry valid.
- out_ready, in, 1, downstream accepts the head entry.
- out_data, out, DATA_W, head payload.
- out_ctrl, out, CTRL_W, head control; all-zero whenever out_valid=0.
- occupancy, out, 2, number of held entries, 0..2.

Function
REQ-003 Transfer rules:
- An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
- An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.

REQ-004 With SKID=0:
- in_ready SHALL equal out_ready OR NOT out_valid (combinational).
- Latency SHALL be 1 cycle.
- occupancy SHALL never exceed 1.

REQ-005 With SKID=1, the block SHALL hold a main register and a skid register. in_ready SHALL be registered and equal 1 exactly when the skid register is empty.

REQ-006 With SKID=1, an accepted entry SHALL be placed as follows:
- into the main register if the main register is empty or is being emptied this cycle;
- otherwise into the skid register.

REQ-007 With SKID=1, on an output transfer while the skid register is full, the skid entry SHALL move to the main register on the same edge.

REQ-008 Entries SHALL leave in strict FIFO order, with no loss and no duplication.

REQ-009 An input transfer and an output transfer on the same edge SHALL leave occupancy unchanged. The new entry SHALL appear at out_* on the next cycle if it becomes the head.

REQ-010 When out_valid=1 and out_ready=0, out_data and out_ctrl SHALL hold stable.

REQ-011 When out_valid=0, out_ctrl SHALL be forced to zero, so that a bubble never asserts MemWr or RegWr. out_data MAY hold its last value.

REQ-012 Flush behaviour:
- flush=1 at a rising edge SHALL clear all valid bits, so occupancy becomes 0 on the next cycle.
- flush SHALL take priority over a simultaneous input transfer; that entry is discarded.
- A simultaneous output transfer on the flush edge SHALL still count as consumed downstream.

REQ-013 In the cycle after a flush, in_ready SHALL be 1 in both SKID modes.

REQ-014 in_data and in_ctrl SHALL be ignored when in_valid=0.

Reset
REQ-015 On reset=1, asynchronously and regardless of clk, the block SHALL:
- clear all valid bits;
- drive out_valid=0, out_ctrl=0, out_data=0 and occupancy=0.

REQ-016 During reset, in_ready SHALL be 0. After the reset deassertion edge, in_ready SHALL be 1 at the first rising clk edge.

REQ-017 Any entry held or in transfer when reset asserts SHALL be discarded.

Configuration
REQ-018 Macro PIPE_STAGE_STATS_EN, when defined, SHALL add two output ports, stall_cnt[15:0] and flush_cnt[15:0].
- stall_cnt increments on each cycle with out_valid=1 and out_ready=0.
- flush_cnt increments on each cycle with flush=1 and occupancy>0.
- Both counters saturate at 16'hFFFF and clear on reset.

REQ-019 When PIPE_STAGE_STATS_EN is undefined, these ports and their counter logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-020 Streaming test: SKID=1, out_ready=1, in_valid=1 for 4 cycles with data 0x11,0x22,0x33,0x44 -> out_data shows 0x11..0x44 on consecutive cycles, one cycle after each input, and occupancy stays 1.

REQ-021 Backpressure test: SKID=1, hold out_ready=0 and offer 0xA, 0xB, 0xC.
- 0xA and 0xB are accepted, occupancy=2, in_ready=0, and 0xC is held upstream.
- Release out_ready -> outputs appear in the order 0xA, 0xB, 0xC.

REQ-022 Flush test: stage holds 2 entries, then flush=1 with in_valid=1 and data 0x55 on the same edge -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0x55 never appears at the output.

REQ-023 Single-register test: SKID=0, out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Setting out_ready=1 -> in_ready=1 combinationally, with the entry swapped on the next edge.

REQ-024 Reset test: assert reset mid-stream with occupancy=2 -> outputs go to zero immediately without a clk edge, and in_ready=1 at the first edge after release.

REQ-025 Statistics test, with PIPE_STAGE_STATS_EN defined: 70000 cycles of out_valid=1 and out_ready=0 -> stall_cnt=16'hFFFF; then 3 flush cycles with occupancy>0 -> flush_cnt=3.
